// File: rtl/pe_fill_buffer.sv
// Per-PE receive buffer: the global controller loads words, the PE reads them by index, then the controller drains them.
// Latency: zero; ready/valid/dout/pe_data are combinational from registered state, and all state moves on posedge clk.
// Backpressure: ready=~full in LOAD only, so a write offered while full is dropped; valid=~empty in DRAIN only.
//
// Ports:
//   clk, rst (sync, active-low), buf_rst (sync soft clear, active-high), change_mode (mode advance pulse)
//   write_en/din/ready  : controller write side, accepted when write_en & ready
//   read_en/dout/valid  : controller drain side, pop when read_en & valid
//   pe_addr/pe_data     : PE random read, relative to head, 0 beyond count
//   mode/count/full/empty : status
module pe_fill_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_rst,
  input  logic              change_mode,
  input  logic              write_en,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  input  logic              read_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  input  logic [ADDR_W-1:0] pe_addr,
  output logic [DATA_W-1:0] pe_data,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } mode_t;

  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  mode_t             state;

  logic              do_write;
  logic              do_pop;
  logic              clear;
  logic [ADDR_W:0]   pe_sum;
  logic [ADDR_W-1:0] pe_idx;

  // Explicit wrap compare so non-power-of-2 depths work.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign clear    = !rst || buf_rst;
  assign mode     = state;
  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign ready    = (state == LOAD) && !full;
  assign valid    = (state == DRAIN) && !empty;
  assign do_write = write_en && ready;
  assign do_pop   = read_en && valid;

  // Head-relative index. pe_data is only driven from memory when pe_addr < count,
  // so rptr + pe_addr < 2*DEPTH and a single conditional subtract is enough.
  always_comb begin
    pe_sum = {1'b0, rptr} + {1'b0, pe_addr};
    if (pe_sum >= CNT_MAX) begin
      pe_sum = pe_sum - CNT_MAX;
    end
    pe_idx = pe_sum[ADDR_W-1:0];
  end

  always_comb begin
    dout    = valid ? mem[rptr] : '0;
    pe_data = ({1'b0, pe_addr} < count) ? mem[pe_idx] : '0;
  end

  // Storage has no reset; a soft clear must leave it untouched.
  always_ff @(posedge clk) begin
    if (!clear && do_write) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      state <= LOAD;
    end else begin
      // Modes are exclusive, so a write and a pop never share a cycle.
      if (do_write) begin
        wptr  <= ptr_inc(wptr);
        count <= count + 1'b1;
      end else if (do_pop) begin
        rptr  <= ptr_inc(rptr);
        count <= count - 1'b1;
      end
      // The operation above uses the current mode; the mode moves at the same edge.
      if (change_mode) begin
        case (state)
          LOAD:    state <= HOLD;
          HOLD:    state <= DRAIN;
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_fill_buffer.sv
module tb_pe_fill_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              buf_rst;
  logic              change_mode;
  logic              write_en;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              read_en;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic [ADDR_W-1:0] pe_addr;
  logic [DATA_W-1:0] pe_data;
  logic [1:0]        mode;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  pe_fill_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .buf_rst(buf_rst), .change_mode(change_mode),
    .write_en(write_en), .din(din), .ready(ready),
    .read_en(read_en), .dout(dout), .valid(valid),
    .pe_addr(pe_addr), .pe_data(pe_data),
    .mode(mode), .count(count), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_mode(input int n);
    change_mode = 1'b1;
    repeat (n) step();
    change_mode = 1'b0;
  endtask

  task automatic load_words(input logic [7:0] base, input int n);
    write_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = base + 8'(i);
      check("load_ready", ready, 1'b1);
      if (ready) sb.push_back(din);
      step();
    end
    write_en = 1'b0;
  endtask

  // Pops up to n words (n<0 means until valid falls), bounded by a cycle budget.
  task automatic drain_words(input string tag, input int n);
    int popped = 0;
    logic [7:0] exp;
    read_en = 1'b1;
    for (int cyc = 0; cyc < 4 * DEPTH; cyc++) begin
      if (n >= 0 && popped == n) break;
      if (!valid) break;
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
      check(tag, dout, exp);
      popped++;
      step();
    end
    read_en = 1'b0;
    if (n >= 0) check({tag, "_popcnt"}, popped, n);
  endtask

  initial begin
    rst = 1'b0; buf_rst = 1'b0; change_mode = 1'b0; write_en = 1'b0;
    din = '0; read_en = 1'b0; pe_addr = '0;

    // 1. Reset
    step(); step();
    check("rst_mode", mode, 2'b00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_valid", valid, 1'b0);
    check("rst_dout", dout, 0);
    check("rst_pe_data", pe_data, 0);
    rst = 1'b1;
    step();

    // 2. Fill to full, then a dropped write
    load_words(8'h10, 8);
    check("fill_count", count, 8);
    check("fill_full", full, 1'b1);
    check("fill_ready", ready, 1'b0);
    write_en = 1'b1; din = 8'hFF;
    step();
    write_en = 1'b0;
    check("drop_count", count, 8);
    check("drop_ready", ready, 1'b0);

    // 3. HOLD: random access, controller ignored
    advance_mode(1);
    check("hold_mode", mode, 2'b01);
    check("hold_ready", ready, 1'b0);
    check("hold_valid", valid, 1'b0);
    pe_addr = 3'd3; #1;
    check("hold_pe3", pe_data, sb[3]);
    pe_addr = 3'd7; #1;
    check("hold_pe7", pe_data, sb[7]);
    write_en = 1'b1; din = 8'hAA; read_en = 1'b1;
    step();
    write_en = 1'b0; read_en = 1'b0;
    check("hold_wr_ign", count, 8);

    // 4. Drain all
    advance_mode(1);
    check("drain_mode", mode, 2'b10);
    check("drain_valid", valid, 1'b1);
    drain_words("drain1", 8);
    check("drain1_valid", valid, 1'b0);
    check("drain1_empty", empty, 1'b1);
    check("drain1_count", count, 0);
    check("drain1_dout", dout, 0);

    // 5. Wrap-around with residual words
    advance_mode(1);
    load_words(8'h20, 5);
    advance_mode(2);
    drain_words("wrap_d3", 3);
    advance_mode(1);
    check("wrap_resid", count, 2);
    check("wrap_mode", mode, 2'b00);
    load_words(8'h30, 6);
    check("wrap_count", count, 8);
    check("wrap_full", full, 1'b1);
    advance_mode(1);
    for (int i = 0; i < DEPTH; i++) begin
      pe_addr = 3'(i); #1;
      check("wrap_pe", pe_data, sb[i]);
    end
    advance_mode(1);
    drain_words("wrap_drain", 8);
    check("wrap_valid", valid, 1'b0);
    check("wrap_sb_left", sb.size(), 0);

    // 6. Soft clear mid-drain with a simultaneous change_mode
    advance_mode(1);
    load_words(8'h40, 6);
    advance_mode(2);
    drain_words("clr_d2", 2);
    check("clr_pre_count", count, 4);
    buf_rst = 1'b1; change_mode = 1'b1;
    step();
    buf_rst = 1'b0; change_mode = 1'b0;
    sb.delete();
    check("clr_mode", mode, 2'b00);
    check("clr_count", count, 0);
    check("clr_valid", valid, 1'b0);
    check("clr_ready", ready, 1'b1);

    // Write together with change_mode: write lands, mode advances.
    write_en = 1'b1; din = 8'h55; change_mode = 1'b1;
    sb.push_back(din);
    step();
    write_en = 1'b0; change_mode = 1'b0;
    check("wcm_mode", mode, 2'b01);
    check("wcm_count", count, 1);
    pe_addr = 3'd0; #1;
    check("wcm_pe0", pe_data, sb[0]);
    pe_addr = 3'd1; #1;
    check("wcm_pe_oob", pe_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
